// File: rtl/window_pkg.sv
// Shared types and defaults for the raster pixel source feeding the 3x3 window pipeline.
// Optional flush tail is enabled with `define FRAME_PIXEL_STREAMER_FLUSH_EN.
package window_pkg;

  localparam int DEF_WIDTH           = 640;
  localparam int DEF_HEIGHT          = 480;
  localparam int DEF_BUS_SIZE        = 25;
  localparam int DEF_NUMBER_OF_LINES = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
`ifdef FRAME_PIXEL_STREAMER_FLUSH_EN
    , S_FLUSH = 2'd3
`endif
  } state_t;

  // Index width for n distinct values, never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Counter width able to hold the value n itself.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pixel_skid_reg.sv
// One-entry holding register that catches a memory return arriving while downstream stalls.
module pixel_skid_reg
  import window_pkg::*;
#(
  parameter int BUS_SIZE = DEF_BUS_SIZE
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic                drain,
  input  logic [BUS_SIZE-1:0] load_data,
  output logic                valid,
  output logic [BUS_SIZE-1:0] skid_data
);

  logic                valid_q, valid_d;
  logic [BUS_SIZE-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid     = valid_q;
  assign skid_data = data_q;

endmodule

// File: rtl/frame_pixel_streamer.sv
// Reads a frame from synchronous memory and streams it in raster order as data/EN with coordinates.
// Define FRAME_PIXEL_STREAMER_FLUSH_EN to append (NUMBER_OF_LINES-1)*WIDTH zero pixels per frame.
module frame_pixel_streamer
  import window_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int HEIGHT          = DEF_HEIGHT,
  parameter int BUS_SIZE        = DEF_BUS_SIZE,
  parameter int NUMBER_OF_LINES = DEF_NUMBER_OF_LINES
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              stall,
  output logic                              rd_en,
  output logic [addr_w(WIDTH*HEIGHT)-1:0]   rd_addr,
  input  logic [BUS_SIZE-1:0]               rd_data,
  output logic [BUS_SIZE-1:0]               data,
  output logic                              EN,
  output logic [addr_w(WIDTH)-1:0]          x_out,
  output logic [addr_w(HEIGHT)-1:0]         y_out,
  output logic                              sof,
  output logic                              eol,
  output logic                              flush,
  output logic                              busy,
  output logic                              done,
  output state_t                            state_dbg
);

  // Handshake: EN=1 marks data as a pixel this cycle; stall=1 in cycle c makes EN=0 in
  // cycle c+1 and holds data/coordinates, with no pixel lost or repeated.
  localparam int N_PIX = WIDTH * HEIGHT;
  localparam int AW    = addr_w(N_PIX);
  localparam int XW    = addr_w(WIDTH);
  localparam int YW    = addr_w(HEIGHT);
  localparam int CW    = cnt_w(N_PIX);
  localparam logic [CW-1:0] N_LAST = CW'(N_PIX);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]       pix_cnt_q, pix_cnt_d;
  logic [XW-1:0]       x_cnt_q, x_cnt_d;
  logic [YW-1:0]       y_cnt_q, y_cnt_d;
  logic                rd_pend_q, rd_pend_d;
  logic [BUS_SIZE-1:0] data_q, data_d;
  logic                en_q, en_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic                sof_q, sof_d;
  logic                eol_q, eol_d;

  logic                rd_en_c;
  logic                skid_valid;
  logic [BUS_SIZE-1:0] skid_data;
  logic                skid_load;
  logic                skid_drain;
  logic                take_frame;

`ifdef FRAME_PIXEL_STREAMER_FLUSH_EN
  localparam int FL_N = (NUMBER_OF_LINES - 1) * WIDTH;
  localparam int FW   = cnt_w(FL_N);
  localparam logic [FW-1:0] FL_LAST = FW'(FL_N);
  logic [FW-1:0] fl_cnt_q, fl_cnt_d;
  logic          flush_q, flush_d;
  logic          take_flush;
`endif

  // Reads are held off while a returned word is parked, so the skid can never overflow.
  assign rd_en_c    = (state_q == S_STREAM) && !stall && (rd_cnt_q < N_LAST) && !skid_valid;
  assign skid_load  = stall && rd_pend_q;
  assign skid_drain = !stall && skid_valid;
  assign take_frame = !stall && (skid_valid || rd_pend_q);
`ifdef FRAME_PIXEL_STREAMER_FLUSH_EN
  assign take_flush = (state_q == S_FLUSH) && !stall && (fl_cnt_q < FL_LAST);
`endif

  pixel_skid_reg #(.BUS_SIZE(BUS_SIZE)) u_skid (
    .clock     (clock),
    .reset     (reset),
    .load      (skid_load),
    .drain     (skid_drain),
    .load_data (rd_data),
    .valid     (skid_valid),
    .skid_data (skid_data)
  );

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    pix_cnt_d = pix_cnt_q;
    x_cnt_d   = x_cnt_q;
    y_cnt_d   = y_cnt_q;
    rd_pend_d = rd_en_c;
    data_d    = data_q;
    en_d      = 1'b0;
    x_d       = x_q;
    y_d       = y_q;
    sof_d     = 1'b0;
    eol_d     = 1'b0;
`ifdef FRAME_PIXEL_STREAMER_FLUSH_EN
    fl_cnt_d  = fl_cnt_q;
    flush_d   = 1'b0;
`endif

    if (rd_en_c) rd_cnt_d = rd_cnt_q + CW'(1);

    if (take_frame) begin
      data_d    = skid_valid ? skid_data : rd_data;
      en_d      = 1'b1;
      x_d       = x_cnt_q;
      y_d       = y_cnt_q;
      sof_d     = (x_cnt_q == '0) && (y_cnt_q == '0);
      eol_d     = (x_cnt_q == X_LAST);
      pix_cnt_d = pix_cnt_q + CW'(1);
      if (x_cnt_q == X_LAST) begin
        x_cnt_d = '0;
        y_cnt_d = y_cnt_q + YW'(1);
      end else begin
        x_cnt_d = x_cnt_q + XW'(1);
      end
    end
`ifdef FRAME_PIXEL_STREAMER_FLUSH_EN
    else if (take_flush) begin
      data_d   = '0;
      en_d     = 1'b1;
      x_d      = '0;
      y_d      = '0;
      flush_d  = 1'b1;
      fl_cnt_d = fl_cnt_q + FW'(1);
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_STREAM;
          rd_cnt_d  = '0;
          pix_cnt_d = '0;
          x_cnt_d   = '0;
          y_cnt_d   = '0;
`ifdef FRAME_PIXEL_STREAMER_FLUSH_EN
          fl_cnt_d  = '0;
`endif
        end
      end
      S_STREAM: begin
        if (pix_cnt_q == N_LAST) begin
`ifdef FRAME_PIXEL_STREAMER_FLUSH_EN
          state_d = S_FLUSH;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef FRAME_PIXEL_STREAMER_FLUSH_EN
      S_FLUSH: begin
        if (fl_cnt_q == FL_LAST) state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rd_cnt_q  <= '0;
      pix_cnt_q <= '0;
      x_cnt_q   <= '0;
      y_cnt_q   <= '0;
      rd_pend_q <= 1'b0;
      data_q    <= '0;
      en_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      x_cnt_q   <= x_cnt_d;
      y_cnt_q   <= y_cnt_d;
      rd_pend_q <= rd_pend_d;
      data_q    <= data_d;
      en_q      <= en_d;
      x_q       <= x_d;
      y_q       <= y_d;
      sof_q     <= sof_d;
      eol_q     <= eol_d;
    end
  end

`ifdef FRAME_PIXEL_STREAMER_FLUSH_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fl_cnt_q <= '0;
      flush_q  <= 1'b0;
    end else begin
      fl_cnt_q <= fl_cnt_d;
      flush_q  <= flush_d;
    end
  end
  assign flush = flush_q;
`else
  assign flush = 1'b0;
`endif

  assign rd_en     = rd_en_c;
  assign rd_addr   = rd_cnt_q[AW-1:0];
  assign data      = data_q;
  assign EN        = en_q;
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Bench for frame_pixel_streamer at 4x3: directed and random-stall frames against a raster-order model.
module tb_frame_pixel_streamer;
  import window_pkg::*;

  localparam int W     = 4;
  localparam int H     = 3;
  localparam int L     = 3;
  localparam int N     = W * H;
  localparam int BW    = 25;
`ifdef FRAME_PIXEL_STREAMER_FLUSH_EN
  localparam int FLN   = (L - 1) * W;
`else
  localparam int FLN   = 0;
`endif
  localparam int TOTAL = N + FLN;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic          rd_en;
  logic [3:0]    rd_addr;
  logic [BW-1:0] rd_data = '0;
  logic [BW-1:0] data;
  logic          EN;
  logic [1:0]    x_out;
  logic [1:0]    y_out;
  logic          sof, eol, flush, busy, done;
  state_t        state_dbg;

  frame_pixel_streamer #(.WIDTH(W), .HEIGHT(H), .BUS_SIZE(BW), .NUMBER_OF_LINES(L)) dut (
    .clock(clock), .reset(reset), .start(start), .stall(stall),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .data(data), .EN(EN), .x_out(x_out), .y_out(y_out),
    .sof(sof), .eol(eol), .flush(flush), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  // clock / reset / memory model
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  logic [BW-1:0] mem [N];
  always @(posedge clock) begin
    if (rd_en) rd_data <= mem[rd_addr];
    else       rd_data <= BW'($urandom);
  end

  // scoreboard state
  int            checks = 0;
  int            errors = 0;
  logic [BW-1:0] exp_q [$];
  logic [BW-1:0] exp_d;
  int            pix_idx, exp_addr, done_cnt;
  int            first_en_rel, last_en_rel, done_rel;
  int            c0 = 0;
  int            rel_m;
  logic          prev_stall;
  logic          mon_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clock) begin
    if (mon_on) begin
      rel_m = cyc - c0;
      if (rd_en) begin
        chk("rd_en_while_stall", 32'(stall), 32'd0);
        chk("rd_addr", 32'(rd_addr), 32'(exp_addr));
        exp_addr++;
      end
      if (prev_stall) chk("en_after_stall", 32'(EN), 32'd0);
      if (EN) begin
        chk("pixel_in_range", 32'(pix_idx < TOTAL), 32'd1);
        if (exp_q.size() > 0) begin
          exp_d = exp_q.pop_front();
          chk("data", 32'(data), 32'(exp_d));
          if (pix_idx < N) begin
            chk("x_out", 32'(x_out), 32'(pix_idx % W));
            chk("y_out", 32'(y_out), 32'(pix_idx / W));
            chk("sof", 32'(sof), 32'(pix_idx == 0));
            chk("eol", 32'(eol), 32'((pix_idx % W) == W - 1));
            chk("flush", 32'(flush), 32'd0);
          end else begin
            chk("flush_xy", 32'({x_out, y_out, sof, eol}), 32'd0);
            chk("flush", 32'(flush), 32'd1);
          end
        end
        if (first_en_rel < 0) first_en_rel = rel_m;
        last_en_rel = rel_m;
        pix_idx++;
      end else begin
        chk("idle_flags", 32'({sof, eol, flush}), 32'd0);
      end
      if (done) begin
        done_cnt++;
        done_rel = rel_m;
        chk("pixels_at_done", 32'(pix_idx), 32'(TOTAL));
      end
      prev_stall = stall;
    end
  end

  task automatic sb_init();
    exp_q.delete();
    for (int k = 0; k < N; k++) exp_q.push_back(mem[k]);
    for (int k = 0; k < FLN; k++) exp_q.push_back('0);
    pix_idx = 0; exp_addr = 0; done_cnt = 0;
    first_en_rel = -1; last_en_rel = -1; done_rel = -1;
    prev_stall = 1'b0;
  endtask

  // mode: 0 none, 1 stall 5..7, 2 random stall, 3 long stall, 4 start while busy, 5 stop after pixel 105
  task automatic run_frame(input int mode, input int budget);
    int rel;
    int n;
    sb_init();
    c0 = cyc;
    mon_on = 1'b1;
    n = 0;
    while (done_cnt == 0 && n < budget && !(mode == 5 && pix_idx >= 6)) begin
      rel = cyc - c0;
      case (mode)
        1:       stall = (rel >= 5 && rel <= 7);
        2:       stall = ($urandom_range(0, 3) == 0);
        3:       stall = (rel >= 2 && rel < 20);
        default: stall = 1'b0;
      endcase
      start = (rel == 0) || (mode == 4 && (rel == 2 || rel == 6 || rel == 10));
      if (mode == 0 && rel == 1) begin
        chk("busy_cycle1", 32'(busy), 32'd1);
        chk("rd_en_cycle1", 32'(rd_en), 32'd1);
        chk("rd_addr_cycle1", 32'(rd_addr), 32'd0);
      end
      @(posedge clock); #1;
      n++;
    end
    start = 1'b0;
    stall = 1'b0;
    if (mode == 5) begin
      chk("reached_pixel_105", 32'(pix_idx >= 6), 32'd1);
      mon_on = 1'b0;
    end else begin
      chk("frame_completed", 32'(done_cnt > 0), 32'd1);
      chk("busy_after_done", 32'(busy), 32'd0);
      if (mode == 0) begin
        chk("first_en_cycle", 32'(first_en_rel), 32'd3);
        chk("last_en_cycle", 32'(last_en_rel), 32'(FLN > 0 ? N + FLN + 3 : N + 2));
        chk("done_cycle", 32'(done_rel), 32'(FLN > 0 ? N + FLN + 4 : N + 3));
      end
      repeat (3) @(posedge clock);
      #1;
      chk("single_done", 32'(done_cnt), 32'd1);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      mon_on = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = BW'(i + 100);
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", 32'({rd_en, rd_addr, EN, x_out, y_out, sof, eol, flush, busy, done}), 32'd0);
    chk("reset_data", 32'(data), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    run_frame(0, 60);
    run_frame(1, 80);
    run_frame(4, 80);
    run_frame(3, 120);

    run_frame(5, 60);
    reset = 1'b1;
    #1;
    chk("midframe_reset_outputs", 32'({rd_en, rd_addr, EN, x_out, y_out, sof, eol, flush, busy, done}), 32'd0);
    chk("midframe_reset_data", 32'(data), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    run_frame(0, 60);

    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++) mem[i] = BW'($urandom);
      run_frame(2, 300);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
